// File: rtl/clasificador_pulsaciones.sv
// rtl/clasificador_pulsaciones.sv - press/release/short/long/auto-repeat event pulses from a debounced button level
// Every output is registered; pulses are one clock wide and come from the next-state logic.

module clasificador_pulsaciones #(
  parameter int CICLOS_LARGA         = 27_000_000,
  parameter int CICLOS_REPETICION    = 5_400_000,
  parameter int HABILITAR_REPETICION = 1,
  parameter int ANCHO_CONTEO         = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    entradaSincronizada,
  output logic                    pulsoSubida,
  output logic                    pulsoBajada,
  output logic                    pulsacionCorta,
  output logic                    pulsacionLarga,
  output logic                    pulsoRepeticion,
  output logic                    presionado,
  output logic [ANCHO_CONTEO-1:0] conteoPulsaciones
);

  localparam int CICLOS_MAX = (CICLOS_LARGA > CICLOS_REPETICION) ? CICLOS_LARGA : CICLOS_REPETICION;
  localparam int ANCHO_TEMP = $clog2(CICLOS_MAX);
  localparam logic [ANCHO_TEMP-1:0] FIN_LARGA      = ANCHO_TEMP'(CICLOS_LARGA - 1);
  localparam logic [ANCHO_TEMP-1:0] FIN_REPETICION = ANCHO_TEMP'(CICLOS_REPETICION - 1);

  typedef enum logic [1:0] {
    REPOSO,
    PRESIONADO,
    LARGO
  } estado_t;

  estado_t                 estado, estado_sig;
  logic                    previo;
  logic [ANCHO_TEMP-1:0]   temporizador, temporizador_sig;
  logic [ANCHO_CONTEO-1:0] conteo_sig;
  logic                    subida, bajada;
  logic                    subida_sig, bajada_sig, corta_sig, larga_sig, repeticion_sig;

  assign subida = entradaSincronizada & ~previo;
  assign bajada = ~entradaSincronizada & previo;

  always_comb begin
    estado_sig       = estado;
    temporizador_sig = temporizador;
    conteo_sig       = conteoPulsaciones;
    subida_sig       = 1'b0;
    bajada_sig       = 1'b0;
    corta_sig        = 1'b0;
    larga_sig        = 1'b0;
    repeticion_sig   = 1'b0;

    case (estado)
      REPOSO: begin
        // A level already high out of reset has no rise, so it is ignored until re-pressed.
        if (subida) begin
          estado_sig       = PRESIONADO;
          temporizador_sig = '0;
          subida_sig       = 1'b1;
          conteo_sig       = conteoPulsaciones + ANCHO_CONTEO'(1);
        end
      end

      PRESIONADO: begin
        if (bajada) begin
          estado_sig       = REPOSO;
          temporizador_sig = '0;
          bajada_sig       = 1'b1;
          corta_sig        = 1'b1;
        end else if (entradaSincronizada) begin
          if (temporizador == FIN_LARGA) begin
            estado_sig       = LARGO;
            temporizador_sig = '0;
            larga_sig        = 1'b1;
          end else begin
            temporizador_sig = temporizador + ANCHO_TEMP'(1);
          end
        end
      end

      LARGO: begin
        if (bajada) begin
          estado_sig       = REPOSO;
          temporizador_sig = '0;
          bajada_sig       = 1'b1;
        end else if (entradaSincronizada) begin
          if (temporizador == FIN_REPETICION) begin
            temporizador_sig = '0;
            repeticion_sig   = (HABILITAR_REPETICION != 0);
          end else begin
            temporizador_sig = temporizador + ANCHO_TEMP'(1);
          end
        end
      end

      default: begin
        estado_sig       = REPOSO;
        temporizador_sig = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado            <= REPOSO;
      temporizador      <= '0;
      previo            <= entradaSincronizada;
      conteoPulsaciones <= '0;
      pulsoSubida       <= 1'b0;
      pulsoBajada       <= 1'b0;
      pulsacionCorta    <= 1'b0;
      pulsacionLarga    <= 1'b0;
      pulsoRepeticion   <= 1'b0;
      presionado        <= 1'b0;
    end else begin
      estado            <= estado_sig;
      temporizador      <= temporizador_sig;
      previo            <= entradaSincronizada;
      conteoPulsaciones <= conteo_sig;
      pulsoSubida       <= subida_sig;
      pulsoBajada       <= bajada_sig;
      pulsacionCorta    <= corta_sig;
      pulsacionLarga    <= larga_sig;
      pulsoRepeticion   <= repeticion_sig;
      presionado        <= (estado_sig != REPOSO);
    end
  end

endmodule

// File: tb/tb_clasificador_pulsaciones.sv
// tb/tb_clasificador_pulsaciones.sv - self-checking bench for clasificador_pulsaciones
// Reference model counts cycles since the press and derives every event arithmetically.

module tb_clasificador_pulsaciones;

  localparam int L = 10;
  localparam int R = 4;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ent = 1'b0;

  logic         sub_a, baj_a, cor_a, lar_a, rep_a, pres_a;
  logic [W-1:0] cnt_a;
  logic         sub_b, baj_b, cor_b, lar_b, rep_b, pres_b;
  logic [W-1:0] cnt_b;

  clasificador_pulsaciones #(
    .CICLOS_LARGA(L), .CICLOS_REPETICION(R), .HABILITAR_REPETICION(1), .ANCHO_CONTEO(W)
  ) dut_a (
    .clk(clk), .rst(rst), .entradaSincronizada(ent),
    .pulsoSubida(sub_a), .pulsoBajada(baj_a), .pulsacionCorta(cor_a),
    .pulsacionLarga(lar_a), .pulsoRepeticion(rep_a), .presionado(pres_a),
    .conteoPulsaciones(cnt_a)
  );

  clasificador_pulsaciones #(
    .CICLOS_LARGA(L), .CICLOS_REPETICION(R), .HABILITAR_REPETICION(0), .ANCHO_CONTEO(W)
  ) dut_b (
    .clk(clk), .rst(rst), .entradaSincronizada(ent),
    .pulsoSubida(sub_b), .pulsoBajada(baj_b), .pulsacionCorta(cor_b),
    .pulsacionLarga(lar_b), .pulsoRepeticion(rep_b), .presionado(pres_b),
    .conteoPulsaciones(cnt_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit m_prev = 1'b0;
  bit m_pressed = 1'b0;
  int m_age = 0;
  int m_cnt = 0;
  bit e_sub, e_baj, e_cor, e_lar, e_rep;

  int n_sub, n_baj, n_cor, n_lar, n_rep, n_rep_b;

  typedef struct {
    bit rst;
    bit ent;
    bit sub;
    bit baj;
    bit cor;
    bit lar;
    bit pres;
    int cnt;
  } vec_t;

  vec_t tabla [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_eventos();
    n_sub = 0; n_baj = 0; n_cor = 0; n_lar = 0; n_rep = 0; n_rep_b = 0;
  endtask

  task automatic step(input bit r, input bit x);
    @(negedge clk);
    rst = r;
    ent = x;
    @(posedge clk);
    #1;
    e_sub = 0; e_baj = 0; e_cor = 0; e_lar = 0; e_rep = 0;
    if (r) begin
      m_pressed = 0;
      m_cnt     = 0;
    end else if (!m_pressed && x && !m_prev) begin
      m_pressed = 1;
      m_age     = 0;
      e_sub     = 1;
      m_cnt     = (m_cnt + 1) % (1 << W);
    end else if (m_pressed && x) begin
      m_age++;
      e_lar = (m_age == L);
      e_rep = (m_age > L) && ((m_age - L) % R == 0);
    end else if (m_pressed && !x) begin
      e_baj     = 1;
      e_cor     = (m_age < L);
      m_pressed = 0;
    end
    m_prev = x;

    chk("pulsoSubida", int'(sub_a), int'(e_sub));
    chk("pulsoBajada", int'(baj_a), int'(e_baj));
    chk("pulsacionCorta", int'(cor_a), int'(e_cor));
    chk("pulsacionLarga", int'(lar_a), int'(e_lar));
    chk("pulsoRepeticion", int'(rep_a), int'(e_rep));
    chk("presionado", int'(pres_a), int'(m_pressed));
    chk("conteoPulsaciones", int'(cnt_a), m_cnt);
    chk("pulsacionLarga_sinrep", int'(lar_b), int'(e_lar));
    chk("pulsoRepeticion_sinrep", int'(rep_b), 0);

    n_sub += int'(sub_a); n_baj += int'(baj_a); n_cor += int'(cor_a);
    n_lar += int'(lar_a); n_rep += int'(rep_a); n_rep_b += int'(rep_b);
  endtask

  task automatic pulsar(input int altos);
    for (int i = 0; i < altos; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    tabla[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tabla[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tabla[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tabla[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tabla[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tabla[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tabla[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};

    clr_eventos();
    for (int i = 0; i < 7; i++) begin
      step(tabla[i].rst, tabla[i].ent);
      chk($sformatf("tabla[%0d].subida", i), int'(sub_a), int'(tabla[i].sub));
      chk($sformatf("tabla[%0d].bajada", i), int'(baj_a), int'(tabla[i].baj));
      chk($sformatf("tabla[%0d].corta", i), int'(cor_a), int'(tabla[i].cor));
      chk($sformatf("tabla[%0d].larga", i), int'(lar_a), int'(tabla[i].lar));
      chk($sformatf("tabla[%0d].presionado", i), int'(pres_a), int'(tabla[i].pres));
      chk($sformatf("tabla[%0d].conteo", i), int'(cnt_a), tabla[i].cnt);
    end

    // Exactly L edges high: boundary resolves as a short press.
    clr_eventos();
    pulsar(L);
    chk("hold10.larga", n_lar, 0);
    chk("hold10.corta", n_cor, 1);

    // L+1 edges high and beyond: long, release without short.
    clr_eventos();
    pulsar(L + 3);
    chk("hold13.larga", n_lar, 1);
    chk("hold13.corta", n_cor, 0);
    chk("hold13.bajada", n_baj, 1);

    clr_eventos();
    pulsar(20);
    chk("hold20.larga", n_lar, 1);
    chk("hold20.repeticion", n_rep, 2);
    chk("hold20.repeticion_sinrep", n_rep_b, 0);

    // Counter wrap through 2^W.
    step(1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b1);
      chk($sformatf("wrap.conteo[%0d]", i), int'(cnt_a), i % 8);
      step(1'b0, 1'b0);
    end

    // Release then immediate re-press.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("repress.bajada", int'(baj_a), 1);
    step(1'b0, 1'b1);
    chk("repress.subida", int'(sub_a), 1);
    chk("repress.bajada_fin", int'(baj_a), 0);
    chk("repress.conteo", int'(cnt_a), 3);
    step(1'b0, 1'b0);

    // Reset while held in LARGO; held level across reset release is not a press.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    clr_eventos();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rstlargo.pulsos", n_sub + n_baj + n_cor + n_lar + n_rep, 0);
    chk("rstlargo.presionado", int'(pres_a), 0);
    step(1'b0, 1'b1);
    chk("rstlargo.subida", int'(sub_a), 1);
    chk("rstlargo.conteo", int'(cnt_a), 1);
    step(1'b0, 1'b0);

    begin
      bit lvl = 1'b0;
      int ciclos = 0;
      while (ciclos < 4000) begin
        int run;
        lvl = ~lvl;
        run = $urandom_range(1, 25);
        for (int i = 0; i < run; i++) begin
          step(($urandom_range(0, 299) == 0), lvl);
          ciclos++;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
